order_matcher: RTL and testbench

// - Upstream matching stage that feeds the spread calculator. Accepts unit-quantity limit orders,

---
 rtl/order_matcher_pkg.sv | 22 ++
 rtl/order_matcher_book_scan.sv | 43 ++++
 rtl/order_matcher.sv | 132 +++++++++++++
 tb/tb_order_matcher.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/order_matcher_pkg.sv
// Shared definitions for the order matching stage.
// Holds the side encodings, the empty-book price markers (also used by the
// spread stage), the FSM state type and the best-price scan direction.
package order_matcher_pkg;

    localparam logic       SIDE_BUY  = 1'b1;
    localparam logic       SIDE_SELL = 1'b0;

    localparam logic [7:0] EMPTY_BID = 8'h00;
    localparam logic [7:0] EMPTY_ASK = 8'hFF;

    typedef enum logic {
        ST_IDLE,
        ST_CHECK
    } state_t;

    typedef enum logic {
        SCAN_MAX,
        SCAN_MIN
    } scan_mode_t;

endpackage

// File: rtl/order_matcher_book_scan.sv
// book_scan: combinational best-price search over one side of the book.
// Ports:
//   valid     in   DEPTH        slot occupied flags
//   price     in   DEPTH x PW   slot prices
//   best      out  PW           max (SCAN_MAX) or min (SCAN_MIN) valid price;
//                               '0 / '1 respectively when no slot is valid
//   best_idx  out  IW           slot index of best; ties resolve to lowest index
//   non_empty out  1            at least one slot valid
module book_scan
    import order_matcher_pkg::*;
#(
    parameter int         DEPTH = 8,
    parameter int         PW    = 8,
    parameter scan_mode_t MODE  = SCAN_MAX
) (
    input  logic [DEPTH-1:0]         valid,
    input  logic [DEPTH-1:0][PW-1:0] price,
    output logic [PW-1:0]            best,
    output logic [$clog2(DEPTH)-1:0] best_idx,
    output logic                     non_empty
);

    localparam int IW = $clog2(DEPTH);

    // Scan upward and replace only on a strictly better price, so the
    // lowest index wins among equal prices.
    always_comb begin
        best      = (MODE == SCAN_MAX) ? '0 : '1;
        best_idx  = '0;
        non_empty = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid[i]) begin
                if (!non_empty ||
                    ((MODE == SCAN_MAX) ? (price[i] > best) : (price[i] < best))) begin
                    best     = price[i];
                    best_idx = IW'(i);
                end
                non_empty = 1'b1;
            end
        end
    end

endmodule

// File: rtl/order_matcher.sv
// order_matcher: unit-quantity limit order book with cross detection.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   order_valid/side/price  order offer (side 1 = buy); prices 0 and all-ones reserved
//   order_ready             high in IDLE; order taken when valid & ready
//   order_reject            1-cycle pulse: last accepted order dropped
//   match_signal            1-cycle pulse: a trade occurred
//   buy_price, sell_price   bid/ask of the last trade, held between trades
//   best_bid, best_ask      current best resting prices (0 / all-ones when empty)
//   bid_count, ask_count    resting orders per side
//   match_count             saturating trade counter
module order_matcher
    import order_matcher_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PW    = 8,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          order_valid,
    input  logic          order_side,
    input  logic [PW-1:0] order_price,
    output logic          order_ready,
    output logic          order_reject,
    output logic          match_signal,
    output logic [PW-1:0] buy_price,
    output logic [PW-1:0] sell_price,
    output logic [PW-1:0] best_bid,
    output logic [PW-1:0] best_ask,
    output logic [4:0]    bid_count,
    output logic [4:0]    ask_count,
    output logic [CW-1:0] match_count
);

    localparam int IW = $clog2(DEPTH);

    state_t                   state;
    logic [DEPTH-1:0]         bid_valid, ask_valid;
    logic [DEPTH-1:0][PW-1:0] bid_price, ask_price;
    logic [IW-1:0]            bid_idx, ask_idx;
    logic [IW-1:0]            bid_free, ask_free;
    logic                     bid_ne, ask_ne;
    logic                     side_full, reserved, accept;

    book_scan #(.DEPTH(DEPTH), .PW(PW), .MODE(SCAN_MAX)) u_bid_scan (
        .valid     (bid_valid),
        .price     (bid_price),
        .best      (best_bid),
        .best_idx  (bid_idx),
        .non_empty (bid_ne)
    );

    book_scan #(.DEPTH(DEPTH), .PW(PW), .MODE(SCAN_MIN)) u_ask_scan (
        .valid     (ask_valid),
        .price     (ask_price),
        .best      (best_ask),
        .best_idx  (ask_idx),
        .non_empty (ask_ne)
    );

    // Lowest free slot per side (scanned from the top so the lowest sticks),
    // plus popcounts of the valid bits.
    always_comb begin
        bid_free  = '0;
        ask_free  = '0;
        bid_count = '0;
        ask_count = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!bid_valid[DEPTH-1-i]) bid_free = IW'(DEPTH-1-i);
            if (!ask_valid[DEPTH-1-i]) ask_free = IW'(DEPTH-1-i);
            bid_count = bid_count + 5'(bid_valid[i]);
            ask_count = ask_count + 5'(ask_valid[i]);
        end
    end

    assign side_full = (order_side == SIDE_BUY) ? (&bid_valid) : (&ask_valid);
    assign reserved  = (order_price == '0) || (order_price == '1);
    assign accept    = order_valid && order_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            order_ready  <= 1'b0;
            order_reject <= 1'b0;
            match_signal <= 1'b0;
            buy_price    <= '0;
            sell_price   <= '1;
            match_count  <= '0;
            bid_valid    <= '0;
            ask_valid    <= '0;
            bid_price    <= '0;
            ask_price    <= '0;
        end else begin
            order_reject <= 1'b0;
            match_signal <= 1'b0;
            case (state)
                ST_IDLE: begin
                    order_ready <= 1'b1;
                    if (accept) begin
                        if (reserved || side_full) begin
                            order_reject <= 1'b1;
                        end else begin
                            if (order_side == SIDE_BUY) begin
                                bid_valid[bid_free] <= 1'b1;
                                bid_price[bid_free] <= order_price;
                            end else begin
                                ask_valid[ask_free] <= 1'b1;
                                ask_price[ask_free] <= order_price;
                            end
                            state       <= ST_CHECK;
                            order_ready <= 1'b0;
                        end
                    end
                end
                ST_CHECK: begin
                    if (bid_ne && ask_ne && (best_bid >= best_ask)) begin
                        bid_valid[bid_idx] <= 1'b0;
                        ask_valid[ask_idx] <= 1'b0;
                        buy_price          <= best_bid;
                        sell_price         <= best_ask;
                        match_signal       <= 1'b1;
                        if (match_count != '1) match_count <= match_count + 1'b1;
                    end
                    state       <= ST_IDLE;
                    order_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_order_matcher.sv
// Self-checking bench for order_matcher: a table of single-order vectors
// with hand-computed book state, plus hand-written reset sequences.
module tb_order_matcher;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       order_valid = 1'b0;
    logic       order_side = 1'b0;
    logic [7:0] order_price = 8'd0;
    logic       order_ready, order_reject, match_signal;
    logic [7:0] buy_price, sell_price, best_bid, best_ask;
    logic [4:0] bid_count, ask_count;
    logic [15:0] match_count;

    int checks = 0;
    int errors = 0;
    int pulses = 0;      // match_signal high cycles seen by the monitor
    int exp_pulses = 0;

    order_matcher #(.DEPTH(8), .PW(8), .CW(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .order_valid  (order_valid),
        .order_side   (order_side),
        .order_price  (order_price),
        .order_ready  (order_ready),
        .order_reject (order_reject),
        .match_signal (match_signal),
        .buy_price    (buy_price),
        .sell_price   (sell_price),
        .best_bid     (best_bid),
        .best_ask     (best_ask),
        .bid_count    (bid_count),
        .ask_count    (ask_count),
        .match_count  (match_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (match_signal) pulses++;
    end

    typedef struct {
        bit rst;
        bit side;
        int price;
        bit match;
        bit rej;
        int bb, ba, bc, ac, bp, sp, mc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rst, bit side, int price, bit match, bit rej,
                                int bb, int ba, int bc, int ac, int bp, int sp, int mc);
        vec_t v;
        v.rst = rst; v.side = side; v.price = price; v.match = match; v.rej = rej;
        v.bb = bb; v.ba = ba; v.bc = bc; v.ac = ac; v.bp = bp; v.sp = sp; v.mc = mc;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, " ready"}, int'(order_ready), 0);
        chk({tag, " reject"}, int'(order_reject), 0);
        chk({tag, " match"}, int'(match_signal), 0);
        chk({tag, " buy_price"}, int'(buy_price), 0);
        chk({tag, " sell_price"}, int'(sell_price), 255);
        chk({tag, " best_bid"}, int'(best_bid), 0);
        chk({tag, " best_ask"}, int'(best_ask), 255);
        chk({tag, " bid_count"}, int'(bid_count), 0);
        chk({tag, " ask_count"}, int'(ask_count), 0);
        chk({tag, " match_count"}, int'(match_count), 0);
    endtask

    task automatic do_reset();
        order_valid = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        reset_n = 1'b1;
    endtask

    // Waits (bounded) for order_ready, then offers one order for one edge.
    task automatic offer(input bit side, input int price);
        for (int n = 0; n < 20 && !order_ready; n++) begin
            @(posedge clk);
            #1;
        end
        chk("ready wait", int'(order_ready), 1);
        order_side  = side;
        order_price = 8'(price);
        order_valid = 1'b1;
        @(posedge clk);
        #1;
        order_valid = 1'b0;
    endtask

    initial begin
        bit rej_seen;
        bit match_seen;

        // Simple cross, no-cross with tie-break, reserved prices.
        vecs.push_back(mk(1, 1, 100, 0, 0, 100, 255, 1, 0,   0, 255, 0));
        vecs.push_back(mk(0, 0,  90, 1, 0,   0, 255, 0, 0, 100,  90, 1));
        vecs.push_back(mk(0, 1,  50, 0, 0,  50, 255, 1, 0, 100,  90, 1));
        vecs.push_back(mk(0, 1,  70, 0, 0,  70, 255, 2, 0, 100,  90, 1));
        vecs.push_back(mk(0, 1,  70, 0, 0,  70, 255, 3, 0, 100,  90, 1));
        vecs.push_back(mk(0, 0,  80, 0, 0,  70,  80, 3, 1, 100,  90, 1));
        vecs.push_back(mk(0, 0,  75, 0, 0,  70,  75, 3, 2, 100,  90, 1));
        vecs.push_back(mk(0, 0,  70, 1, 0,  70,  75, 2, 2,  70,  70, 2));
        vecs.push_back(mk(0, 0, 255, 0, 1,  70,  75, 2, 2,  70,  70, 2));
        vecs.push_back(mk(0, 1,   0, 0, 1,  70,  75, 2, 2,  70,  70, 2));
        vecs.push_back(mk(0, 0,   0, 0, 1,  70,  75, 2, 2,  70,  70, 2));
        vecs.push_back(mk(0, 1, 255, 0, 1,  70,  75, 2, 2,  70,  70, 2));
        // Full buy book: 8 accepted, 9th rejected, then crosses against it.
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(i == 1, 1, 10, 0, 0, 10, 255, i, 0, 0, 255, 0));
        vecs.push_back(mk(0, 1, 10, 0, 1, 10, 255, 8, 0,  0, 255, 0));
        vecs.push_back(mk(0, 0, 10, 1, 0, 10, 255, 7, 0, 10,  10, 1));
        vecs.push_back(mk(0, 0, 11, 0, 0, 10,  11, 7, 1, 10,  10, 1));
        vecs.push_back(mk(0, 1, 11, 1, 0, 10, 255, 7, 0, 11,  11, 2));
        vecs.push_back(mk(0, 1,  9, 0, 0, 10, 255, 8, 0, 11,  11, 2));
        vecs.push_back(mk(0, 1, 12, 0, 1, 10, 255, 8, 0, 11,  11, 2));

        do_reset();

        foreach (vecs[k]) begin
            if (vecs[k].rst) do_reset();
            offer(vecs[k].side, vecs[k].price);
            rej_seen = order_reject;
            @(posedge clk);
            #1;
            match_seen = match_signal;
            if (vecs[k].match) exp_pulses++;
            @(negedge clk);
            #1;
            chk($sformatf("v%0d reject", k), int'(rej_seen), int'(vecs[k].rej));
            chk($sformatf("v%0d match", k), int'(match_seen), int'(vecs[k].match));
            chk($sformatf("v%0d best_bid", k), int'(best_bid), vecs[k].bb);
            chk($sformatf("v%0d best_ask", k), int'(best_ask), vecs[k].ba);
            chk($sformatf("v%0d bid_count", k), int'(bid_count), vecs[k].bc);
            chk($sformatf("v%0d ask_count", k), int'(ask_count), vecs[k].ac);
            chk($sformatf("v%0d buy_price", k), int'(buy_price), vecs[k].bp);
            chk($sformatf("v%0d sell_price", k), int'(sell_price), vecs[k].sp);
            chk($sformatf("v%0d match_count", k), int'(match_count), vecs[k].mc);
            chk($sformatf("v%0d pulses", k), pulses, exp_pulses);
        end

        // Match pulse lasts exactly one cycle.
        do_reset();
        offer(1, 120);
        @(posedge clk);
        #1;
        offer(0, 110);
        chk("pulse k", int'(match_signal), 0);
        @(posedge clk);
        #1;
        chk("pulse k+1", int'(match_signal), 1);
        chk("pulse bp", int'(buy_price), 120);
        chk("pulse sp", int'(sell_price), 110);
        @(posedge clk);
        #1;
        chk("pulse k+2", int'(match_signal), 0);
        exp_pulses++;

        // Reset asserted while the crossing order is in CHECK.
        do_reset();
        offer(1, 100);
        @(posedge clk);
        #1;
        offer(0, 90);
        chk("midchk ready", int'(order_ready), 0);
        reset_n = 1'b0;
        #1;
        check_reset_values("midchk");
        @(posedge clk);
        #1;
        chk("midchk match", int'(match_signal), 0);
        @(negedge clk);
        #1;
        chk("midchk pulses", pulses, exp_pulses);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post ready", int'(order_ready), 1);
        chk("post bid_count", int'(bid_count), 0);
        chk("post ask_count", int'(ask_count), 0);
        chk("post match_count", int'(match_count), 0);
        chk("post pulses", pulses, exp_pulses);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
